disp_value_ctrl: RTL and testbench

Sequencing controller that feeds the 3-digit seven-segment multiplexer. It accepts a signed 10-bit binary value over a valid/ready handshake and converts it to BCD with an iterative double-dabble FSM. It then formats the result into three 5-bit display codes, applying sign, leading-zero blanking and overflow dashes, and drives per-digit enables for optional blinking. It sits between application logic and the display mux; its outputs connect directly to the mux's hex2..hex0, dp_in and en_in.

---
 rtl/disp_pkg.sv | 17 +
 rtl/dabble_step.sv | 23 ++
 rtl/disp_value_ctrl.sv | 150 +++++++++++++++
 tb/tb_disp_value_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared display codes, state encoding and BCD width
package disp_pkg;

  // Three decimal digits of four bits each
  localparam int BCD_W = 12;

  localparam logic [4:0] CODE_DASH  = 5'h11;
  localparam logic [4:0] CODE_BLANK = 5'h12;
  localparam logic [4:0] CODE_ZERO  = 5'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

endpackage

// File: rtl/dabble_step.sv
// rtl/dabble_step.sv - one combinational double-dabble iteration
module dabble_step
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             mag_msb,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BCD_W-1:0] adj;

  // Add 3 to every nibble >= 5, then shift left pulling in the next magnitude bit
  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
    bcd_out = {adj[BCD_W-2:0], mag_msb};
  end

endmodule

// File: rtl/disp_value_ctrl.sv
// rtl/disp_value_ctrl.sv - signed value to 3-digit display code sequencer
module disp_value_ctrl
  import disp_pkg::*;
#(
  parameter int BLINK_W = 24,
  parameter int VAL_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val_valid,
  output logic             val_ready,
  input  logic [VAL_W-1:0] val_data,
  input  logic             blink,
  input  logic [2:0]       dp_req,
  output logic [4:0]       hex2,
  output logic [4:0]       hex1,
  output logic [4:0]       hex0,
  output logic [2:0]       dp_out,
  output logic [2:0]       en_out
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   mag_q, mag_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_r_q, blink_r_d;
  logic [2:0]         en_q, en_d;
  logic [2:0]         dp_q, dp_d;

  logic [BCD_W-1:0]   bcd_step;
  logic [4:0]         fmt2, fmt1, fmt0;
  logic [3:0]         dig2, dig1, dig0;

  dabble_step u_dabble_step (
    .bcd_in  (bcd_q),
    .mag_msb (mag_q[VAL_W-1]),
    .bcd_out (bcd_step)
  );

  assign val_ready = (state_q == ST_IDLE);

  assign dig2 = bcd_q[11:8];
  assign dig1 = bcd_q[7:4];
  assign dig0 = bcd_q[3:0];

  // Map converted digits to display codes: blanking, sign dash placement, overflow
  always_comb begin
    fmt2 = {1'b0, dig2};
    fmt1 = {1'b0, dig1};
    fmt0 = {1'b0, dig0};
    if (!sign_q) begin
      if (dig2 == 4'd0) begin
        fmt2 = CODE_BLANK;
        if (dig1 == 4'd0) fmt1 = CODE_BLANK;
      end
    end else if (dig2 != 4'd0) begin
      fmt2 = CODE_DASH;
      fmt1 = CODE_DASH;
      fmt0 = CODE_DASH;
    end else if (dig1 != 4'd0) begin
      fmt2 = CODE_DASH;
    end else begin
      fmt2 = CODE_BLANK;
      fmt1 = CODE_DASH;
    end
  end

  // Next-state: accept, shift VAL_W bits, format; plus blink and dp pipelines
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    hex2_d      = hex2_q;
    hex1_d      = hex1_q;
    hex0_d      = hex0_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_r_d   = blink;
    en_d        = blink_r_q ? {3{~blink_cnt_q[BLINK_W-1]}} : 3'b111;
    dp_d        = dp_req;
    case (state_q)
      ST_IDLE: begin
        if (val_valid) begin
          sign_d  = val_data[VAL_W-1];
          mag_d   = val_data[VAL_W-1] ? (~val_data + VAL_W'(1)) : val_data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_step;
        mag_d = {mag_q[VAL_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) state_d = ST_FORMAT;
      end
      ST_FORMAT: begin
        hex2_d  = fmt2;
        hex1_d  = fmt1;
        hex0_d  = fmt0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hex2_q      <= CODE_BLANK;
      hex1_q      <= CODE_BLANK;
      hex0_q      <= CODE_ZERO;
      blink_cnt_q <= '0;
      blink_r_q   <= 1'b0;
      en_q        <= 3'b111;
      dp_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hex2_q      <= hex2_d;
      hex1_q      <= hex1_d;
      hex0_q      <= hex0_d;
      blink_cnt_q <= blink_cnt_d;
      blink_r_q   <= blink_r_d;
      en_q        <= en_d;
      dp_q        <= dp_d;
    end
  end

  assign hex2   = hex2_q;
  assign hex1   = hex1_q;
  assign hex0   = hex0_q;
  assign en_out = en_q;
  assign dp_out = dp_q;

endmodule

// File: tb/tb_disp_value_ctrl.sv
// tb/tb_disp_value_ctrl.sv - directed self-checking bench for disp_value_ctrl
module tb_disp_value_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              val_valid;
  logic              val_ready;
  logic signed [9:0] val_data;
  logic              blink;
  logic [2:0]        dp_req;
  logic [4:0]        hex2, hex1, hex0;
  logic [2:0]        dp_out;
  logic [2:0]        en_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [14:0] prev_hex;

  disp_value_ctrl #(.BLINK_W(4), .VAL_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .val_data  (val_data),
    .blink     (blink),
    .dp_req    (dp_req),
    .hex2      (hex2),
    .hex1      (hex1),
    .hex0      (hex0),
    .dp_out    (dp_out),
    .en_out    (en_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] h3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {a, b, c};
  endfunction

  // Accept one value, confirm ready stays low and display holds for edges T..T+10, then updates at T+11
  task automatic convert(input string tag, input logic signed [9:0] v, input logic [14:0] exp);
    check({tag, "_ready_pre"}, 32'(val_ready), 32'(1));
    val_valid = 1'b1;
    val_data  = v;
    tick();
    val_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check({tag, "_busy"}, 32'({val_ready, hex2, hex1, hex0}), 32'({1'b0, prev_hex}));
      if (i < 10) tick();
    end
    tick();
    check({tag, "_hex"}, 32'({hex2, hex1, hex0}), 32'(exp));
    check({tag, "_ready_post"}, 32'(val_ready), 32'(1));
    prev_hex = exp;
  endtask

  initial begin
    reset     = 1'b1;
    val_valid = 1'b0;
    val_data  = '0;
    blink     = 1'b0;
    dp_req    = 3'b000;
    prev_hex  = h3(5'h12, 5'h12, 5'h00);
    tick();
    tick();
    check("ready_in_reset", 32'(val_ready), 32'(1));
    reset = 1'b0;
    tick();
    check("reset_hex", 32'({hex2, hex1, hex0}), 32'(h3(5'h12, 5'h12, 5'h00)));
    check("reset_en", 32'(en_out), 32'(3'b111));
    check("reset_dp", 32'(dp_out), 32'(3'b000));
    check("reset_ready", 32'(val_ready), 32'(1));

    convert("v123", 10'sd123, h3(5'h01, 5'h02, 5'h03));
    convert("v7",   10'sd7,   h3(5'h12, 5'h12, 5'h07));
    convert("v0",   10'sd0,   h3(5'h12, 5'h12, 5'h00));
    convert("v511", 10'sd511, h3(5'h05, 5'h01, 5'h01));
    convert("vm5",  -10'sd5,  h3(5'h12, 5'h11, 5'h05));
    convert("vm45", -10'sd45, h3(5'h11, 5'h04, 5'h05));
    convert("vm100", -10'sd100, h3(5'h11, 5'h11, 5'h11));
    convert("vm512", -10'sd512, h3(5'h11, 5'h11, 5'h11));
    convert("v10",  10'sd10,  h3(5'h12, 5'h01, 5'h00));

    // Valid held through FORMAT: not taken at T+11, taken at T+12
    val_valid = 1'b1;
    val_data  = 10'sd300;
    tick();
    val_data  = -10'sd45;
    for (int i = 0; i < 10; i++) tick();
    tick();
    check("hold_first_hex", 32'({hex2, hex1, hex0}), 32'(h3(5'h03, 5'h00, 5'h00)));
    check("hold_ready_after_format", 32'(val_ready), 32'(1));
    tick();
    check("hold_accept_next_edge", 32'(val_ready), 32'(0));
    val_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("hold_second_pending", 32'({hex2, hex1, hex0}), 32'(h3(5'h03, 5'h00, 5'h00)));
    tick();
    check("hold_second_hex", 32'({hex2, hex1, hex0}), 32'(h3(5'h11, 5'h04, 5'h05)));
    check("hold_second_ready", 32'(val_ready), 32'(1));
    prev_hex = h3(5'h11, 5'h04, 5'h05);

    // Busy with 42; a pulse carrying 200 mid-conversion must be ignored
    val_valid = 1'b1;
    val_data  = 10'sd42;
    tick();
    val_valid = 1'b0;
    tick();
    tick();
    val_valid = 1'b1;
    val_data  = 10'sd200;
    tick();
    val_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("busy_ready_low", 32'(val_ready), 32'(0));
    tick();
    check("busy_hex", 32'({hex2, hex1, hex0}), 32'(h3(5'h12, 5'h04, 5'h02)));
    check("busy_ready", 32'(val_ready), 32'(1));
    tick();
    tick();
    check("busy_no_requeue", 32'(val_ready), 32'(1));

    // Abort mid-conversion at SHIFT cycle 5
    val_valid = 1'b1;
    val_data  = 10'sd99;
    tick();
    val_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_busy", 32'(val_ready), 32'(0));
    blink  = 1'b1;
    reset  = 1'b1;
    #1;
    check("abort_hex", 32'({hex2, hex1, hex0}), 32'(h3(5'h12, 5'h12, 5'h00)));
    check("abort_ready", 32'(val_ready), 32'(1));
    check("abort_en", 32'(en_out), 32'(3'b111));
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_hex = h3(5'h12, 5'h12, 5'h00);

    // Blink: counter restarts at 0; en after edge k reflects counter value k-1, one extra edge for blink_r
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("blink_k%0d", k), 32'(en_out),
            32'((k == 1) ? 3'b111 : ((((k - 1) >> 3) & 1) != 0 ? 3'b000 : 3'b111)));
    end
    blink = 1'b0;
    tick();
    check("blink_off_lag", 32'(en_out), 32'(3'b000));
    tick();
    check("blink_off_en", 32'(en_out), 32'(3'b111));

    // Decimal points: one-cycle registered pass-through
    dp_req = 3'b101;
    #1;
    check("dp_before_edge", 32'(dp_out), 32'(3'b000));
    tick();
    check("dp_after_edge", 32'(dp_out), 32'(3'b101));
    dp_req = 3'b010;
    tick();
    check("dp_second", 32'(dp_out), 32'(3'b010));

    convert("v_after_abort", 10'sd64, h3(5'h12, 5'h06, 5'h04));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
